// File: rtl/i2s_feed_arbiter.sv
// i2s_feed_arbiter: shares the I2S FIFO write port between two stereo frame sources.
// Build macro I2S_ARB_MIX_EN: mode 3 saturating-mixes both sources; otherwise mode 3 is round-robin.
module i2s_feed_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_soc,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [47:0]      s0_frame,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [47:0]      s1_frame,
    input  logic             s1_valid,
    output logic             s1_ready,
    output logic [47:0]      frame_out,
    output logic             write_frame,
    input  logic             full,
    output logic             last_grant,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        pend_valid;
    logic [47:0] pend_frame;
    logic        accept_ok;
    logic        mix_sel;
    logic        acc0;
    logic        acc1;
    logic        accept;
    logic [47:0] load_frame;

`ifdef I2S_ARB_MIX_EN
    function automatic logic signed [23:0] sat_add24(input logic signed [23:0] a,
                                                     input logic signed [23:0] b);
        logic signed [24:0] sum;
        sum = {a[23], a} + {b[23], b};
        // The two top bits disagree only when the sum left the 24-bit range.
        if (sum[24] != sum[23])
            return sum[24] ? 24'sh800000 : 24'sh7FFFFF;
        return sum[23:0];
    endfunction

    logic signed [23:0] mix_l;
    logic signed [23:0] mix_r;

    assign mix_sel = (mode == 2'd3);
    assign mix_l   = sat_add24(s0_frame[47:24], s1_frame[47:24]);
    assign mix_r   = sat_add24(s0_frame[23:0], s1_frame[23:0]);
`else
    assign mix_sel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_soc) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (write_frame && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Outputs: write strobe and source readies
    always_comb begin
        pend_valid  = (state == FULL);
        write_frame = pend_valid & ~full & ~reset;
        accept_ok   = enable & (~pend_valid | ~full) & ~reset;
        s0_ready    = 1'b0;
        s1_ready    = 1'b0;
        if (accept_ok) begin
            case (mode)
                2'd0: s0_ready = 1'b1;
                2'd1: s1_ready = 1'b1;
                default: begin
                    if (mix_sel) begin
                        s0_ready = s0_valid & s1_valid;
                        s1_ready = s0_valid & s1_valid;
                    end else begin
                        // On a tie the source that did not win last time goes next.
                        s0_ready = s0_valid & (~s1_valid | last_grant);
                        s1_ready = s1_valid & (~s0_valid | ~last_grant);
                    end
                end
            endcase
        end
    end

    assign acc0   = s0_ready & s0_valid;
    assign acc1   = s1_ready & s1_valid;
    assign accept = acc0 | acc1;

    always_comb begin
        load_frame = acc1 ? s1_frame : s0_frame;
`ifdef I2S_ARB_MIX_EN
        if (mix_sel)
            load_frame = {mix_l, mix_r};
`endif
    end

    always_ff @(posedge clk_soc) begin
        if (reset) begin
            pend_frame  <= '0;
            last_grant  <= 1'b1;
            frame_count <= '0;
        end else begin
            if (accept)
                pend_frame <= load_frame;
            if (accept && !mix_sel)
                last_grant <= acc1;
            if (write_frame)
                frame_count <= frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign frame_out = pend_frame;

endmodule

// File: tb/tb_i2s_feed_arbiter.sv
// tb_i2s_feed_arbiter: scoreboard bench for i2s_feed_arbiter (default or I2S_ARB_MIX_EN build).
module tb_i2s_feed_arbiter;

    logic        clk_soc = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [47:0] s0_frame;
    logic        s0_valid;
    logic        s0_ready;
    logic [47:0] s1_frame;
    logic        s1_valid;
    logic        s1_ready;
    logic [47:0] frame_out;
    logic        write_frame;
    logic        full;
    logic        last_grant;
    logic [15:0] frame_count;

    logic [47:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk_soc = ~clk_soc;

    i2s_feed_arbiter #(.CNT_W(16)) dut (
        .clk_soc    (clk_soc),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .s0_frame   (s0_frame),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s1_frame   (s1_frame),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .frame_out  (frame_out),
        .write_frame(write_frame),
        .full       (full),
        .last_grant (last_grant),
        .frame_count(frame_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every FIFO write must match the oldest expected frame.
    always @(negedge clk_soc) begin
        if (write_frame === 1'b1) begin
            if (exp_q.size() == 0)
                chk("unexpected_write", 64'd1, 64'd0);
            else
                chk("frame_out", {16'd0, frame_out}, {16'd0, exp_q.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk_soc);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_soc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        mode     = 2'd0;
        s0_frame = '0;
        s0_valid = 1'b0;
        s1_frame = '0;
        s1_valid = 1'b0;
        full     = 1'b0;
        step();
        step();
        mid();
        chk("rst_write", 64'(write_frame), 64'd0);
        chk("rst_frame_out", 64'(frame_out), 64'd0);
        chk("rst_last_grant", 64'(last_grant), 64'd1);
        chk("rst_count", 64'(frame_count), 64'd0);
        step();
        reset  = 1'b0;
        enable = 1'b1;

        // Single frame from source 0
        s0_frame = 48'h000001_000002;
        s0_valid = 1'b1;
        exp_q.push_back(48'h000001_000002);
        mid();
        chk("m0_s0_ready", 64'(s0_ready), 64'd1);
        chk("m0_s1_ready", 64'(s1_ready), 64'd0);
        step();
        s0_valid = 1'b0;
        mid();
        chk("m0_latency_write", 64'(write_frame), 64'd1);
        chk("m0_s1_ready_b", 64'(s1_ready), 64'd0);
        step();
        chk("m0_count", 64'(frame_count), 64'd1);
        chk("m0_last_grant", 64'(last_grant), 64'd0);

        // Round-robin with both sources always valid
        do_reset();
        mode     = 2'd2;
        s0_frame = 48'hAAAAAA_AAAAAA;
        s1_frame = 48'h555555_555555;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back((i % 2 == 0) ? 48'hAAAAAA_AAAAAA : 48'h555555_555555);
            mid();
            chk("rr_s0_ready", 64'(s0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_s1_ready", 64'(s1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            step();
            chk("rr_last_grant", 64'(last_grant), 64'(i % 2));
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        drain();
        chk("rr_count", 64'(frame_count), 64'd4);

        // Back-pressure: stall then release with simultaneous accept
        do_reset();
        mode     = 2'd0;
        full     = 1'b1;
        s0_frame = 48'h123456_654321;
        s0_valid = 1'b1;
        exp_q.push_back(48'h123456_654321);
        step();
        s0_frame = 48'h0ABCDE_0FEDCB;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("stall_write", 64'(write_frame), 64'd0);
            chk("stall_s0_ready", 64'(s0_ready), 64'd0);
            chk("stall_frame_out", 64'(frame_out), 64'h123456_654321);
            step();
        end
        full = 1'b0;
        exp_q.push_back(48'h0ABCDE_0FEDCB);
        mid();
        chk("release_write", 64'(write_frame), 64'd1);
        chk("release_s0_ready", 64'(s0_ready), 64'd1);
        step();
        s0_valid = 1'b0;
        drain();
        chk("stall_count", 64'(frame_count), 64'd2);

        // Mode 3
        do_reset();
        mode     = 2'd3;
        s0_frame = {24'h7FFFF0, 24'h800005};
        s1_frame = {24'h000020, 24'hFFFFF0};
        s0_valid = 1'b1;
`ifdef I2S_ARB_MIX_EN
        mid();
        chk("mix_lone_s0_ready", 64'(s0_ready), 64'd0);
        chk("mix_lone_s1_ready", 64'(s1_ready), 64'd0);
        step();
        s1_valid = 1'b1;
        exp_q.push_back({24'h7FFFFF, 24'h800000});
        mid();
        chk("mix_s0_ready", 64'(s0_ready), 64'd1);
        chk("mix_s1_ready", 64'(s1_ready), 64'd1);
        step();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        drain();
        chk("mix_last_grant", 64'(last_grant), 64'd1);
`else
        exp_q.push_back({24'h7FFFF0, 24'h800005});
        mid();
        chk("m3rr_s0_ready", 64'(s0_ready), 64'd1);
        chk("m3rr_s1_ready", 64'(s1_ready), 64'd0);
        step();
        s0_valid = 1'b0;
        s1_valid = 1'b1;
        exp_q.push_back({24'h000020, 24'hFFFFF0});
        mid();
        chk("m3rr_s1_only", 64'(s1_ready), 64'd1);
        step();
        s1_valid = 1'b0;
        drain();
        chk("m3rr_last_grant", 64'(last_grant), 64'd1);
`endif

        // Enable dropped with a pending, stalled frame
        do_reset();
        mode     = 2'd0;
        full     = 1'b1;
        s0_frame = 48'h000777_000888;
        s0_valid = 1'b1;
        exp_q.push_back(48'h000777_000888);
        step();
        enable   = 1'b0;
        s0_frame = 48'h000999_000AAA;
        step();
        mid();
        chk("en_off_s0_ready", 64'(s0_ready), 64'd0);
        step();
        full = 1'b0;
        mid();
        chk("en_off_write", 64'(write_frame), 64'd1);
        chk("en_off_no_accept", 64'(s0_ready), 64'd0);
        step();
        step();
        mid();
        chk("en_off_idle", 64'(write_frame), 64'd0);
        chk("en_off_count", 64'(frame_count), 64'd1);
        s0_valid = 1'b0;
        enable   = 1'b1;
        drain();

        // Counter wrap after 65536 writes
        do_reset();
        mode     = 2'd0;
        s0_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            s0_frame = {24'(i), 24'(~i)};
            exp_q.push_back({24'(i), 24'(~i)});
            step();
        end
        s0_valid = 1'b0;
        chk("wrap_pre", 64'(frame_count), 64'hFFFF);
        drain();
        chk("wrap_zero", 64'(frame_count), 64'd0);

        // Reset while a frame is pending
        s0_frame = 48'h111111_222222;
        s0_valid = 1'b1;
        exp_q.push_back(48'h111111_222222);
        step();
        s0_frame = 48'h333333_444444;
        step();
        s0_valid = 1'b0;
        full     = 1'b1;
        mid();
        chk("prerst_count", 64'(frame_count), 64'd1);
        step();
        reset = 1'b1;
        full  = 1'b0;
        mid();
        chk("rst_mid_write", 64'(write_frame), 64'd0);
        step();
        reset = 1'b0;
        mid();
        chk("rst_mid_count", 64'(frame_count), 64'd0);
        chk("rst_mid_frame", 64'(frame_out), 64'd0);
        chk("rst_mid_write_b", 64'(write_frame), 64'd0);
        step();
        chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
